// File: rtl/guess_entry.sv
// Bulls-and-Cows guess entry: conditions the enter button, collects four distinct
// decimal digits, offers them over valid/ready and drives the digit previews.
module guess_entry #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [3:0]  i_code,
    input  logic        i_enter_button,
    input  logic        i_clear,
    input  logic        i_guess_ready,
    output logic        o_guess_valid,
    output logic [15:0] o_guess,
    output logic [2:0]  o_entry_count,
    output logic        o_reject,
    output logic [5:0]  o_p1,
    output logic [5:0]  o_p2,
    output logic [5:0]  o_p3,
    output logic [5:0]  o_p4
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {S_COLLECT, S_OFFER} state_t;

    logic          r_btn_s1, r_btn_s2;
    logic [3:0]    r_code_s1, r_code_s2;
    logic          r_db, r_db_prev;
    logic [CW-1:0] r_db_cnt;
    logic          w_press;

    state_t          r_state, w_state_nxt;
    logic [3:0][3:0] r_dig, w_dig_nxt;
    logic [2:0]      r_count, w_count_nxt;
    logic            r_reject, w_reject_nxt;
    logic            w_dup;
    logic [3:0][5:0] w_prev;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_btn_s1  <= 1'b0;
            r_btn_s2  <= 1'b0;
            r_code_s1 <= '0;
            r_code_s2 <= '0;
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_btn_s1  <= i_enter_button;
            r_btn_s2  <= r_btn_s1;
            r_code_s1 <= i_code;
            r_code_s2 <= r_code_s1;
            r_db_prev <= r_db;
            // Counter measures how long the synchronised level has disagreed.
            if (r_btn_s2 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_db     <= r_btn_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + CW'(1);
            end
        end
    end

    assign w_press = r_db & ~r_db_prev;

    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < 4; i++)
            if (3'(i) < r_count && r_dig[i] == r_code_s2) w_dup = 1'b1;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_dig_nxt    = r_dig;
        w_count_nxt  = r_count;
        w_reject_nxt = 1'b0;
        if (i_clear) begin
            w_state_nxt = S_COLLECT;
            w_dig_nxt   = '0;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_press) begin
                        if (r_code_s2 > 4'd9 || w_dup) begin
                            w_reject_nxt = 1'b1;
                        end else begin
                            w_dig_nxt[r_count[1:0]] = r_code_s2;
                            w_count_nxt = r_count + 3'd1;
                            if (r_count == 3'd3) w_state_nxt = S_OFFER;
                        end
                    end
                end
                S_OFFER: begin
                    if (i_guess_ready) begin
                        w_state_nxt = S_COLLECT;
                        w_dig_nxt   = '0;
                        w_count_nxt = '0;
                    end
                end
                default: w_state_nxt = S_COLLECT;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_COLLECT;
            r_dig    <= '0;
            r_count  <= '0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dig    <= w_dig_nxt;
            r_count  <= w_count_nxt;
            r_reject <= w_reject_nxt;
        end
    end

    // Stored slots lit, cursor shows only its dp, slots past the cursor dark.
    always_comb begin
        w_prev = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_state == S_OFFER || 3'(i) < r_count)
                w_prev[i] = {1'b1, r_dig[i], 1'b0};
            else if (3'(i) == r_count)
                w_prev[i] = 6'h01;
        end
    end

    assign o_guess_valid = (r_state == S_OFFER);
    assign o_guess       = {r_dig[0], r_dig[1], r_dig[2], r_dig[3]};
    assign o_entry_count = r_count;
    assign o_reject      = r_reject;
    assign o_p1          = w_prev[0];
    assign o_p2          = w_prev[1];
    assign o_p3          = w_prev[2];
    assign o_p4          = w_prev[3];
endmodule

// File: doc/guess_entry.md
# guess_entry

Front-end input block for the Bulls and Cows game on the Nexys A7. It synchronises and debounces the raw enter button and samples the 4-bit code switches on each clean press. It assembles four distinct decimal digits into a guess and hands the guess to the game core over a valid/ready handshake. It also produces four 6-bit digit words showing the entry in progress, in the same format the display driver consumes.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before the debounced button level changes (10 ms at 100 MHz).
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- code  in  4  raw switch value; legal digits are 0-9.
- enter_button  in  1  raw, asynchronous push button.
- clear  in  1  discards any partial or offered guess (new round).
- guess_ready  in  1  game core accepts the guess.
- guess_valid  out  1  a complete guess is offered.
- guess  out  16  {digit0, digit1, digit2, digit3}; the first-entered digit is in [15:12].
- entry_count  out  3  number of digits stored, 0-4.
- reject  out  1  one-cycle pulse when a press is refused.
- p1, p2, p3, p4  out  6  preview digit words, {enable, value[3:0], dp}; p1 is slot 0.

## Operation
- Input conditioning:
  - enter_button and code each pass through a 2-flop synchroniser.
  - The debounce counter resets whenever the synchronised button equals the debounced level.
  - The debounced level flips when the two have differed for DEBOUNCE_CYCLES consecutive cycles.
  - press is a one-cycle pulse on each rising edge of the debounced level.
- FSM states: COLLECT (reset state) and OFFER.
- COLLECT, on press, with the sampled value being the synchronised code in the press cycle:
  - If code > 9, or code equals any already-stored digit: pulse reject and leave storage unchanged.
  - Otherwise: store code at slot entry_count and increment entry_count.
  - If this store is the 4th digit, the same edge enters OFFER.
- OFFER:
  - guess_valid = 1; guess and the previews are held stable.
  - Presses are ignored, with no reject pulse.
  - On guess_valid && guess_ready: return to COLLECT, clear all digits to 0, set entry_count to 0.
- clear, in any state:
  - Next state is COLLECT, storage is zeroed, entry_count = 0, no reject pulse.
  - Clear takes priority over a same-cycle press.
  - If clear coincides with a handshake, the transfer counts as done; the end state is identical.
- Preview words:
  - A stored slot shows {1, digit, 0}.
  - In COLLECT, the cursor slot (index entry_count) shows {0, 0000, 1}.
  - Empty slots beyond the cursor show 6'h00.
  - In OFFER, all four slots are lit with dp = 0.
- guess always reflects the storage: unfilled digits read 0, and guess is meaningful only while guess_valid = 1.

## Timing
- Reset values:
  - guess_valid = 0, guess = 16'h0000, entry_count = 0, reject = 0.
  - p1 = 6'h01; p2, p3, p4 = 6'h00.
  - Debounced level = 0, debounce counter = 0, state = COLLECT.
- A button held through reset produces exactly one press, DEBOUNCE_CYCLES + 2 cycles after reset deasserts.
- Press latency:
  - The raw edge reaches the synchronised level after 2 cycles.
  - press asserts DEBOUNCE_CYCLES cycles later.
- Update timing:
  - Storage, entry_count and the previews update on the edge ending the press cycle.
  - reject is high during the cycle after the press cycle, for exactly one cycle.
- 4th digit: guess_valid rises on the same edge that stores it, so entry_count = 4 and guess_valid = 1 appear together.
- Handshake:
  - The transfer happens on the edge where guess_valid && guess_ready.
  - guess_valid = 0 and entry_count = 0 from the next cycle.
  - guess_ready is don't-care while guess_valid = 0.
- A bounce shorter than DEBOUNCE_CYCLES cycles generates no press.
- A button held high generates exactly one press.
- Synchronous reset mid-operation (any state) restores all reset values on the next cycle and drops any offered guess.

## Test plan
- DEBOUNCE_CYCLES = 4 for all scenarios.
- Scenario 1, normal entry: reset, then press with code = 1, 2, 3, 4 -> guess_valid = 1, guess = 16'h1234, entry_count = 4, p1..p4 = 6'h22, 6'h24, 6'h26, 6'h28.
- Scenario 2, illegal digits: press 5, then press 5 again -> one-cycle reject, entry_count stays 1, p2 = 6'h01. Then code = 4'hA -> reject, no change.
- Scenario 3, bounce rejection:
  - Toggle enter_button with high pulses of 3 cycles -> no press, entry_count unchanged.
  - Hold it high for 20 cycles -> exactly one digit stored.
- Scenario 4, backpressure:
  - After scenario 1, hold guess_ready = 0 for 10 cycles and press twice -> guess stays 16'h1234, no reject.
  - Raise guess_ready for 1 cycle -> next cycle guess_valid = 0, entry_count = 0, guess = 16'h0000, p1 = 6'h01.
- Scenario 5, clear mid-entry: enter 7, 8, then assert clear in the same cycle as a press of 9 -> entry_count = 0, p1 = 6'h01, no reject, 9 not stored.
- Scenario 6, reset in OFFER: complete a guess, then assert reset one cycle with guess_ready = 0 -> all outputs at reset values on the next cycle.
